gray_mem_arbiter: RTL

Round-robin burst arbiter sharing the single read port of the gray-image memory between two pixel-fetch requesters (the LBP engine and a second image-filter core). Grants the port in bursts of up to BURST reads, one neighbourhood window, so a requester's window fetch is not interleaved. Returns read data with a 1-cycle latency and a per-requester valid strobe. Sits between the fetch engines and the gray memory interface.

---
 rtl/gray_mem_arbiter_if.sv | 43 ++++
 rtl/gray_mem_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/gray_mem_arbiter_if.sv
// gray_mem_arbiter_if
// Bundles every bus signal around the gray-image memory read arbiter.
//   master : arbiter side. Drives the memory read strobe/address, the grants,
//            and the per-requester return strobes and data.
//   slave  : environment side. Drives the memory ready/data and the requests
//            and addresses of the two fetch engines.
// Signals:
//   mem_ready, mem_rd, mem_addr[AW], mem_data[DW]  - memory read port
//   req0/1, addr0/1[AW]                            - requester inputs
//   gnt0/1, dvalid0/1, data0/1[DW]                 - requester outputs
interface gray_mem_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
);

  logic          mem_ready;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;

  logic          gnt0;
  logic          gnt1;
  logic          dvalid0;
  logic          dvalid1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;

  modport master (
    input  mem_ready, mem_data, req0, req1, addr0, addr1,
    output mem_rd, mem_addr, gnt0, gnt1, dvalid0, dvalid1, data0, data1
  );

  modport slave (
    output mem_ready, mem_data, req0, req1, addr0, addr1,
    input  mem_rd, mem_addr, gnt0, gnt1, dvalid0, dvalid1, data0, data1
  );

endinterface

// File: rtl/gray_mem_arbiter.sv
// gray_mem_arbiter
// Round-robin burst arbiter that shares the single read port of the gray-image
// memory between two pixel-fetch requesters. The port is owned for up to BURST
// accepted reads at a time, so one requester's window fetch is never
// interleaved with the other's. Read data returns one cycle after each
// accepted read, steered to the requester that issued it.
// Ports:
//   clk    - clock, all logic on the rising edge
//   reset  - synchronous, active-high
//   bus    - gray_mem_arbiter_if.master (memory port plus both requesters)
module gray_mem_arbiter #(
  parameter int AW    = 14,
  parameter int DW    = 8,
  parameter int BURST = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  gray_mem_arbiter_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    cnt;
  logic          last;
  logic          own_req;
  logic          beat;
  logic          end_cond;
  logic          cnt_clr;
  logic          dvalid0_q;
  logic          dvalid1_q;
  logic [DW-1:0] data0_q;
  logic [DW-1:0] data1_q;
  logic [AW-1:0] addr_sel;

  // Request level of whoever currently owns the port (don't-care in IDLE).
  assign own_req  = (state == OWN1) ? bus.req1 : bus.req0;
  assign beat     = (state != IDLE) && own_req && bus.mem_ready;

  // A burst ends either on its last accepted read or when the owner lets go.
  assign end_cond = (state != IDLE) &&
                    ((beat && (cnt == 4'(BURST - 1))) || !own_req);

  // Owner 1 gets its own address; otherwise addr0 is presented, which is a
  // don't-care in IDLE because mem_rd is low there.
  assign addr_sel     = (state == OWN1) ? bus.addr1 : bus.addr0;
  assign bus.mem_addr = addr_sel;
  assign bus.mem_rd   = beat;
  assign bus.gnt0     = (state == OWN0);
  assign bus.gnt1     = (state == OWN1);

  // The memory presents data one cycle after acceptance, so the returned
  // pixel is passed straight through while dvalid is high and the registered
  // copy keeps it visible afterwards.
  assign bus.dvalid0  = dvalid0_q;
  assign bus.dvalid1  = dvalid1_q;
  assign bus.data0    = dvalid0_q ? bus.mem_data : data0_q;
  assign bus.data1    = dvalid1_q ? bus.mem_data : data1_q;

  // The counter restarts on any grant change and also when the same owner is
  // re-granted after exhausting its burst.
  assign cnt_clr = (state_next != state) || end_cond;

  // Next-state logic: a tie from IDLE goes to the requester that did not own
  // the port last; at the end of a burst the other requester is preferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_next = last ? OWN0 : OWN1;
        end else if (bus.req0) begin
          state_next = OWN0;
        end else if (bus.req1) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (end_cond) begin
          if (bus.req1) begin
            state_next = OWN1;
          end else if (bus.req0) begin
            state_next = OWN0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      OWN1: begin
        if (end_cond) begin
          if (bus.req0) begin
            state_next = OWN0;
          end else if (bus.req1) begin
            state_next = OWN1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, beat counter, round-robin pointer and the read-return path.
  // Reset drops any pending return so nothing is reported after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 1'b1;
      dvalid0_q <= 1'b0;
      dvalid1_q <= 1'b0;
      data0_q   <= '0;
      data1_q   <= '0;
    end else begin
      state <= state_next;
      if (cnt_clr) begin
        cnt <= 4'd0;
      end else if (beat) begin
        cnt <= cnt + 4'd1;
      end
      if ((state != IDLE) && (state_next != state)) begin
        last <= (state == OWN1);
      end
      dvalid0_q <= beat && (state == OWN0);
      dvalid1_q <= beat && (state == OWN1);
      data0_q   <= bus.data0;
      data1_q   <= bus.data1;
    end
  end

endmodule
